// File: rtl/tb_event_monitor.sv
// Event monitor: arms on i_start, waits for an edge/level on one selected channel,
// reports done/timeout with the elapsed ARMED cycle count. Optional per-channel
// rising-edge counters are enabled with `define TB_EVENT_MONITOR_CNT_EN.
module tb_event_monitor #(
  parameter int unsigned G_NB_CHANNELS   = 8,
  parameter int unsigned G_TIMEOUT_WIDTH = 32,
  localparam int unsigned SEL_W = (G_NB_CHANNELS > 1) ? $clog2(G_NB_CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [G_NB_CHANNELS-1:0]   i_signals,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [SEL_W-1:0]           i_sel,
  input  logic [1:0]                 i_mode,
  input  logic [G_TIMEOUT_WIDTH-1:0] i_timeout,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_timeout,
  output logic [G_TIMEOUT_WIDTH-1:0] o_elapsed
`ifdef TB_EVENT_MONITOR_CNT_EN
  ,
  output logic [G_NB_CHANNELS*16-1:0] o_edge_cnt
`endif
);

  localparam int unsigned PAD_W = 1 << SEL_W;
  localparam int unsigned TW    = G_TIMEOUT_WIDTH;

  typedef enum logic [0:0] {ST_IDLE, ST_ARMED} state_t;

  state_t                   state_q, state_d;
  logic [G_NB_CHANNELS-1:0] s_cur, s_prev;
  logic [SEL_W-1:0]         sel_q;
  logic [1:0]               mode_q;
  logic [TW-1:0]            tmo_q;
  logic [TW-1:0]            cnt_q, cnt_d;
  logic [TW-1:0]            elapsed_d;
  logic                     latch_c, done_d, tmo_d, busy_d;
  logic                     match_c, timeout_hit_c;
  logic [PAD_W-1:0]         cur_pad_c, prev_pad_c;
  logic                     cur_bit_c, prev_bit_c, sel_ok_c, raw_c;

  // Channel match on the latched selection; out-of-range channels never match
  always_comb begin
    cur_pad_c  = PAD_W'(s_cur);
    prev_pad_c = PAD_W'(s_prev);
    cur_bit_c  = cur_pad_c[sel_q];
    prev_bit_c = prev_pad_c[sel_q];
    sel_ok_c   = (32'(sel_q) < G_NB_CHANNELS);
    case (mode_q)
      2'b00:   raw_c = cur_bit_c & ~prev_bit_c;
      2'b01:   raw_c = ~cur_bit_c & prev_bit_c;
      2'b10:   raw_c = cur_bit_c;
      default: raw_c = ~cur_bit_c;
    endcase
    match_c       = sel_ok_c & raw_c;
    timeout_hit_c = (tmo_q != '0) && (cnt_q == (tmo_q - TW'(1)));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    elapsed_d = o_elapsed;
    latch_c   = 1'b0;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          state_d = ST_ARMED;
          latch_c = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (match_c) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          elapsed_d = cnt_q;
        end else if (timeout_hit_c) begin
          state_d   = ST_IDLE;
          tmo_d     = 1'b1;
          elapsed_d = tmo_q;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ARMED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s_cur     <= '0;
      s_prev    <= '0;
      sel_q     <= '0;
      mode_q    <= '0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      o_elapsed <= '0;
    end else begin
      state_q   <= state_d;
      s_cur     <= i_signals;
      s_prev    <= s_cur;
      cnt_q     <= cnt_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
      o_timeout <= tmo_d;
      o_elapsed <= elapsed_d;
      if (latch_c) begin
        sel_q  <= i_sel;
        mode_q <= i_mode;
        tmo_q  <= i_timeout;
      end
    end
  end

`ifdef TB_EVENT_MONITOR_CNT_EN
  logic [G_NB_CHANNELS-1:0] rise_c;
  assign rise_c = s_cur & ~s_prev;

  // Saturating per-channel rising-edge counters, cleared only by reset
  for (genvar n = 0; n < int'(G_NB_CHANNELS); n++) begin : g_edge_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o_edge_cnt[16*n +: 16] <= '0;
      end else if (rise_c[n] && (o_edge_cnt[16*n +: 16] != 16'hFFFF)) begin
        o_edge_cnt[16*n +: 16] <= o_edge_cnt[16*n +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tb_event_monitor.sv
// Directed self-checking bench for tb_event_monitor (6 channels, 16-bit timeout).
module tb_tb_event_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  sig;
  logic        start, abort;
  logic [2:0]  sel;
  logic [1:0]  mode;
  logic [15:0] tmo;
  logic        busy, done, tout;
  logic [15:0] elapsed;
`ifdef TB_EVENT_MONITOR_CNT_EN
  logic [95:0] edge_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  tb_event_monitor #(.G_NB_CHANNELS(6), .G_TIMEOUT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_signals(sig), .i_start(start), .i_abort(abort),
    .i_sel(sel), .i_mode(mode), .i_timeout(tmo), .o_busy(busy), .o_done(done),
    .o_timeout(tout), .o_elapsed(elapsed)
`ifdef TB_EVENT_MONITOR_CNT_EN
    , .o_edge_cnt(edge_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an arm request for one edge; returns just after the arming edge (k=0)
  task automatic arm(input logic [2:0] s, input logic [1:0] m, input logic [15:0] t);
    sel = s; mode = m; tmo = t; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sig = '0; start = 0; abort = 0; sel = '0; mode = '0; tmo = '0;
    repeat (3) tick();
    n_checks++; if ({busy, done, tout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b exp 000", {busy, done, tout}); end
    n_checks++; if (elapsed !== 16'd0) begin n_fail++; $display("FAIL reset_elapsed: got %0d exp 0", elapsed); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_rise_match();
    arm(3'd3, 2'b00, 16'd100);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rise_busy: got %b exp 1", busy); end
    repeat (9) tick();
    sig[3] = 1'b1;
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rise_early: got %b exp 0", done); end
    tick();
    n_checks++; if ({done, tout, busy} !== 3'b100) begin n_fail++; $display("FAIL rise_pulse: got %b exp 100", {done, tout, busy}); end
    n_checks++; if (elapsed !== 16'd10) begin n_fail++; $display("FAIL rise_elapsed: got %0d exp 10", elapsed); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rise_single: got %b exp 0", done); end
  endtask

  task automatic test_timeout();
    sig = '0;
    repeat (3) tick();
    arm(3'd0, 2'b01, 16'd20);
    // Changes while armed would match immediately if they were honoured
    sel = 3'd1; mode = 2'b11; tmo = 16'd3; start = 1'b1;
    tick();
    n_checks++; if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL tmo_ignore: got %b exp 01", {done, busy}); end
    repeat (18) tick();
    start = 1'b0;
    n_checks++; if ({tout, busy} !== 2'b01) begin n_fail++; $display("FAIL tmo_early: got %b exp 01", {tout, busy}); end
    tick();
    n_checks++; if ({tout, done, busy} !== 3'b100) begin n_fail++; $display("FAIL tmo_pulse: got %b exp 100", {tout, done, busy}); end
    n_checks++; if (elapsed !== 16'd20) begin n_fail++; $display("FAIL tmo_elapsed: got %0d exp 20", elapsed); end
  endtask

  task automatic test_level();
    sig[5] = 1'b1;
    repeat (3) tick();
    arm(3'd5, 2'b10, 16'd0);
    n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL lvl_armed: got %b exp 10", {busy, done}); end
    tick();
    n_checks++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL lvl_done: got %b exp 10", {done, busy}); end
    n_checks++; if (elapsed !== 16'd0) begin n_fail++; $display("FAIL lvl_elapsed: got %0d exp 0", elapsed); end
    arm(3'd2, 2'b11, 16'd0);
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL lvl_low_done: got %b exp 1", done); end
  endtask

  task automatic test_fall_match();
    sig[4] = 1'b1;
    repeat (3) tick();
    arm(3'd4, 2'b01, 16'd0);
    sig[4] = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL fall_early: got %b exp 0", done); end
    tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL fall_done: got %b exp 1", done); end
    n_checks++; if (elapsed !== 16'd1) begin n_fail++; $display("FAIL fall_elapsed: got %0d exp 1", elapsed); end
  endtask

  task automatic test_abort_range();
    logic seen;
    seen = 1'b0;
    sig = '1;
    repeat (3) tick();
    arm(3'd7, 2'b10, 16'd0);
    for (int i = 0; i < 49; i++) begin
      tick();
      seen = seen | done | tout;
    end
    n_checks++; if ({busy, seen} !== 2'b10) begin n_fail++; $display("FAIL oor_wait: got %b exp 10", {busy, seen}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if ({busy, done, tout} !== 3'b000) begin n_fail++; $display("FAIL abort_flags: got %b exp 000", {busy, done, tout}); end
    n_checks++; if (elapsed !== 16'd1) begin n_fail++; $display("FAIL abort_elapsed: got %0d exp 1", elapsed); end
    arm(3'd5, 2'b10, 16'd0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rearm_busy: got %b exp 1", busy); end
    tick();
    n_checks++; if ({done, elapsed} !== {1'b1, 16'd0}) begin n_fail++; $display("FAIL rearm_done: got %b/%0d exp 1/0", done, elapsed); end
  endtask

  task automatic test_idle_abort();
    start = 1'b1; abort = 1'b1; sel = 3'd5; mode = 2'b10; tmo = '0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort: got %b exp 0", busy); end
    start = 1'b0;
    tick();
    abort = 1'b0;
    n_checks++; if ({busy, done, tout} !== 3'b000) begin n_fail++; $display("FAIL idle_abort: got %b exp 000", {busy, done, tout}); end
  endtask

  task automatic test_abort_priority();
    // T=1 and level present: match and timeout both due at k=0, abort wins
    arm(3'd5, 2'b10, 16'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if ({busy, done, tout} !== 3'b000) begin n_fail++; $display("FAIL abort_prio: got %b exp 000", {busy, done, tout}); end
  endtask

  task automatic test_collision();
    sig = '0;
    repeat (3) tick();
    arm(3'd3, 2'b00, 16'd5);
    repeat (3) tick();
    sig[3] = 1'b1;
    tick();
    n_checks++; if ({busy, done, tout} !== 3'b100) begin n_fail++; $display("FAIL coll_pre: got %b exp 100", {busy, done, tout}); end
    tick();
    n_checks++; if ({done, tout, busy} !== 3'b100) begin n_fail++; $display("FAIL coll_pulse: got %b exp 100", {done, tout, busy}); end
    n_checks++; if (elapsed !== 16'd4) begin n_fail++; $display("FAIL coll_elapsed: got %0d exp 4", elapsed); end
  endtask

  task automatic test_reset_armed();
    arm(3'd7, 2'b00, 16'd0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, done, tout} !== 3'b000) begin n_fail++; $display("FAIL rst_arm_flags: got %b exp 000", {busy, done, tout}); end
    n_checks++; if (elapsed !== 16'd0) begin n_fail++; $display("FAIL rst_arm_elapsed: got %0d exp 0", elapsed); end
    #1;
    rst_n = 1'b1;
    sig = 6'b100000;
    repeat (2) tick();
    arm(3'd5, 2'b10, 16'd0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_rearm_busy: got %b exp 1", busy); end
    tick();
    n_checks++; if ({done, elapsed} !== {1'b1, 16'd0}) begin n_fail++; $display("FAIL rst_rearm_done: got %b/%0d exp 1/0", done, elapsed); end
  endtask

`ifdef TB_EVENT_MONITOR_CNT_EN
  task automatic test_edge_cnt();
    logic [15:0] f;
    rst_n = 1'b0; sig = '0;
    #2;
    rst_n = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 70000; i++) begin
      sig[1] = 1'b1; tick();
      sig[1] = 1'b0; tick();
    end
    repeat (2) tick();
    for (int n = 0; n < 6; n++) begin
      f = edge_cnt[16*n +: 16];
      n_checks++;
      if (f !== ((n == 1) ? 16'hFFFF : 16'h0000)) begin
        n_fail++; $display("FAIL edge_cnt_%0d: got %h exp %h", n, f, (n == 1) ? 16'hFFFF : 16'h0000);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rise_match();
    test_timeout();
    test_level();
    test_fall_match();
    test_abort_range();
    test_idle_abort();
    test_abort_priority();
    test_collision();
    test_reset_armed();
`ifdef TB_EVENT_MONITOR_CNT_EN
    test_edge_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
